// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen
//   Multi-channel edge detector and fixed-width pulse generator. Each channel
//   synchronises an asynchronous level, detects rising/falling/both edges
//   according to its mode, and turns each accepted edge into a PULSE_LEN-cycle
//   pulse followed by an optional HOLDOFF lockout window. Accepted edges set a
//   sticky flag and bump a saturating counter.
//
// Ports
//   clk    : single clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   din    : [CH]       asynchronous level inputs
//   mode   : [2*CH]     per channel {2i+1:2i}: 00 rise, 01 fall, 10 both, 11 off
//   clr    : [CH]       synchronous clear of flag[i] and channel i counter
//   pulse  : [CH]       registered edge pulse, PULSE_LEN cycles wide
//   flag   : [CH]       sticky accepted-edge flag
//   any    : 1          registered OR of pulse, aligned with pulse
//   cnt    : [CH*CNT_W] channel i at [CNT_W*i +: CNT_W], saturating count
module edge_pulse_gen #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int HOLDOFF     = 0,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         din,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         clr,
  output logic [CH-1:0]         pulse,
  output logic [CH-1:0]         flag,
  output logic                  any,
  output logic [CH*CNT_W-1:0]   cnt
);

  localparam int RMAX  = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int REM_W = $clog2(RMAX + 1);
  localparam int WU_W  = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0] WU_DONE = WU_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLD} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Warm-up: masks detection while the synchronisers refill after reset
  logic [WU_W-1:0] wu_p0;
  logic            warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wu_p0 <= '0;
    else if (wu_p0 != WU_DONE) wu_p0 <= wu_p0 + 1'b1;
  end

  assign warm = (wu_p0 == WU_DONE);

  // Synchroniser chains and previous-sample register
  logic [CH-1:0][SYNC_STAGES-1:0] sync_p0;
  logic [CH-1:0]                  s;
  logic [CH-1:0]                  prev_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      prev_p1 <= '0;
    end else begin
      for (int i = 0; i < CH; i++)
        sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], din[i]};
      prev_p1 <= s;
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < CH; i++) s[i] = sync_p0[i][SYNC_STAGES-1];
  end

  // Per-channel detection, FSM and event bookkeeping
  logic [CH-1:0] pulse_nxt;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t            st_p2, st_nxt;
    logic [REM_W-1:0]  rem_p2, rem_nxt;
    logic              rise, fall, edg, last_cyc, acc, pulse_d;
    logic              pulse_p2, flag_p2;
    logic [CNT_W-1:0]  cnt_p2;

    assign rise = s[g] & ~prev_p1[g];
    assign fall = ~s[g] & prev_p1[g];

    always_comb begin
      case (mode[2*g +: 2])
        2'b00:   edg = rise;
        2'b01:   edg = fall;
        2'b10:   edg = rise | fall;
        default: edg = 1'b0;
      endcase
    end

    // The final cycle of the active window may take a new edge, giving
    // back-to-back pulses with no idle gap.
    assign last_cyc = ((st_p2 == S_PULSE) && (rem_p2 == REM_W'(1)) && (HOLDOFF == 0)) ||
                      ((st_p2 == S_HOLD)  && (rem_p2 == REM_W'(1)));
    assign acc = warm & edg & ((st_p2 == S_IDLE) | last_cyc);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_p2  <= S_IDLE;
        rem_p2 <= '0;
      end else begin
        st_p2  <= st_nxt;
        rem_p2 <= rem_nxt;
      end
    end

    always_comb begin
      st_nxt  = st_p2;
      rem_nxt = rem_p2;
      if (acc) begin
        st_nxt  = S_PULSE;
        rem_nxt = REM_W'(PULSE_LEN);
      end else begin
        case (st_p2)
          S_PULSE: begin
            if (rem_p2 > REM_W'(1)) begin
              rem_nxt = rem_p2 - 1'b1;
            end else if (HOLDOFF == 0) begin
              st_nxt  = S_IDLE;
              rem_nxt = '0;
            end else begin
              st_nxt  = S_HOLD;
              rem_nxt = REM_W'(HOLDOFF);
            end
          end
          S_HOLD: begin
            if (rem_p2 > REM_W'(1)) begin
              rem_nxt = rem_p2 - 1'b1;
            end else begin
              st_nxt  = S_IDLE;
              rem_nxt = '0;
            end
          end
          default: ;
        endcase
      end
    end

    always_comb begin
      pulse_d = (st_nxt == S_PULSE);
    end

    // Output registers; an accepted edge overrides a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pulse_p2 <= 1'b0;
        flag_p2  <= 1'b0;
        cnt_p2   <= '0;
      end else begin
        pulse_p2 <= pulse_d;
        if (acc) begin
          flag_p2 <= 1'b1;
          cnt_p2  <= clr[g] ? CNT_W'(1) : sat_inc(cnt_p2);
        end else if (clr[g]) begin
          flag_p2 <= 1'b0;
          cnt_p2  <= '0;
        end
      end
    end

    assign pulse_nxt[g]          = pulse_d;
    assign pulse[g]              = pulse_p2;
    assign flag[g]               = flag_p2;
    assign cnt[CNT_W*g +: CNT_W] = cnt_p2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any <= 1'b0;
    else        any <= |pulse_nxt;
  end

endmodule
